disp_wr_arbiter: RTL

- Arbitrates the single write port of the LED display controller's digit memory between two requesters: A (processor/AXI register writes) and B (FIR status/overlay writes).
- After reset, and on demand, runs a clear sweep that writes a blank pattern into every digit slot before it accepts any requests.
- Sits directly in front of the display controller and drives its address, data, write-enable and output-enable inputs.

---
 rtl/disp_wr_arbiter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/disp_wr_arbiter.sv
// ---------------------------------------------------------------------------
// disp_wr_arbiter
//
// Owns the single write port of the LED display controller's digit memory.
// Two requesters share that port:
//   A - processor / AXI register writes
//   B - FIR status / overlay writes
// After reset, and whenever i_clr pulses, a clear sweep first writes
// CLEAR_VAL into slots 0..DEPTH-1 with the display output disabled. Only then
// are requests accepted. Ties are broken round-robin.
//
// Optional build macro:
//   DISP_ARB_STATS_EN - adds o_cnt_a / o_cnt_b, which are saturating 16-bit
//                       counts of completed transfers per requester.
//
// Ports:
//   clk        in   system clock
//   i_rst_n    in   asynchronous active-low reset
//   i_clr      in   one-cycle pulse that requests a new clear sweep
//   i_vld_a    in   requester A write valid
//   i_addr_a   in   requester A address
//   i_di_a     in   requester A data
//   o_rdy_a    out  requester A ready (combinational); the transfer happens
//                   when i_vld_a & o_rdy_a
//   i_vld_b    in   requester B write valid
//   i_addr_b   in   requester B address
//   i_di_b     in   requester B data
//   o_rdy_b    out  requester B ready (combinational)
//   o_addr     out  registered write address to the display controller
//   o_di       out  registered write data
//   o_we       out  registered write enable, a one-cycle pulse per write
//   o_oe       out  registered display output enable, low while clearing
//   o_busy     out  high while the clear sweep is running
//   o_cnt_a    out  (DISP_ARB_STATS_EN) count of completed A transfers
//   o_cnt_b    out  (DISP_ARB_STATS_EN) count of completed B transfers
// ---------------------------------------------------------------------------
module disp_wr_arbiter #(
    parameter int                 ADDR_W    = 6,
    parameter int                 DATA_W    = 16,
    parameter int                 DEPTH     = 16,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_vld_a,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [DATA_W-1:0] i_di_a,
    output logic              o_rdy_a,
    input  logic              i_vld_b,
    input  logic [ADDR_W-1:0] i_addr_b,
    input  logic [DATA_W-1:0] i_di_b,
    output logic              o_rdy_b,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_di,
    output logic              o_we,
    output logic              o_oe,
    output logic              o_busy
`ifdef DISP_ARB_STATS_EN
    ,
    output logic [15:0]       o_cnt_a,
    output logic [15:0]       o_cnt_b
`endif
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              last_b_q;   // 1: B held the most recent grant
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] di_q;
    logic              we_q;
    logic              oe_q;
    logic              busy_q;

    logic              gnt_a;
    logic              gnt_b;

    // Grant decision. A request is only granted in ARB, and never in a
    // cycle where i_clr is high, because the clear takes priority. When both
    // requesters are valid, the one not granted last wins. Because the
    // pointer starts as "B last", A wins the first tie after reset.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (state_q == ST_ARB && !i_clr) begin
            if (i_vld_a && (!i_vld_b || last_b_q)) begin
                gnt_a = 1'b1;
            end else if (i_vld_b) begin
                gnt_b = 1'b1;
            end
        end
    end

    assign o_rdy_a = gnt_a;
    assign o_rdy_b = gnt_b;

    // Sweep counter next value. It wraps to 0 on the last slot, so the next
    // sweep always starts clean. A clear request also restarts it at 0.
    always_comb begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (i_clr || cnt_q == LAST_SLOT) begin
            cnt_d = '0;
        end
    end

    // Control FSM and registered write port. Everything the display
    // controller sees comes from a flop, so the output timing does not depend
    // on the requesters' combinational paths.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_CLEAR;
            cnt_q    <= '0;
            last_b_q <= 1'b1;
            addr_q   <= '0;
            di_q     <= '0;
            we_q     <= 1'b0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    we_q   <= 1'b1;
                    addr_q <= cnt_q;
                    di_q   <= CLEAR_VAL;
                    oe_q   <= 1'b0;
                    busy_q <= 1'b1;
                    cnt_q  <= cnt_d;
                    // A clear request during the sweep only rewinds the
                    // counter. This cycle's write still goes out.
                    if (!i_clr && cnt_q == LAST_SLOT) begin
                        state_q <= ST_ARB;
                    end
                end

                ST_ARB: begin
                    if (i_clr) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                        we_q    <= 1'b0;
                        oe_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        oe_q   <= 1'b1;
                        busy_q <= 1'b0;
                        we_q   <= gnt_a | gnt_b;
                        // When no write happens, address and data hold their
                        // last values.
                        if (gnt_a) begin
                            addr_q   <= i_addr_a;
                            di_q     <= i_di_a;
                            last_b_q <= 1'b0;
                        end else if (gnt_b) begin
                            addr_q   <= i_addr_b;
                            di_q     <= i_di_b;
                            last_b_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= ST_CLEAR;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign o_addr = addr_q;
    assign o_di   = di_q;
    assign o_we   = we_q;
    assign o_oe   = oe_q;
    assign o_busy = busy_q;

`ifdef DISP_ARB_STATS_EN
    logic [15:0] cnt_a_q;
    logic [15:0] cnt_b_q;
    logic [15:0] cnt_a_d;
    logic [15:0] cnt_b_d;

    // Saturating transfer counters. A clear request zeroes them. A grant can
    // never coincide with i_clr, so the clear cannot swallow a transfer.
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (i_clr) begin
            cnt_a_d = '0;
            cnt_b_d = '0;
        end else begin
            if (gnt_a && cnt_a_q != 16'hFFFF) begin
                cnt_a_d = cnt_a_q + 16'd1;
            end
            if (gnt_b && cnt_b_q != 16'hFFFF) begin
                cnt_b_d = cnt_b_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign o_cnt_a = cnt_a_q;
    assign o_cnt_b = cnt_b_q;
`endif

endmodule
